// File: rtl/bus_io_pkg.sv
// Shared definitions for the 65C02 I/O-page responder (bus_io_target).
// Register offsets inside the page, CTRL/STATUS bit positions, the
// access FSM state type and the default I/O page.
package bus_io_pkg;

  localparam logic [7:0] IO_PAGE_DEFAULT = 8'hD0;

  localparam logic [2:0] OFS_CNT_LO   = 3'd0;
  localparam logic [2:0] OFS_CNT_HI   = 3'd1;
  localparam logic [2:0] OFS_CTRL     = 3'd2;
  localparam logic [2:0] OFS_STATUS   = 3'd3;
  localparam logic [2:0] OFS_NMI_TRIG = 3'd4;
  localparam logic [2:0] OFS_SCRATCH  = 3'd5;
  localparam logic [2:0] OFS_WAIT     = 3'd6;
  localparam logic [2:0] OFS_PRESCALE = 3'd7;

  localparam int unsigned CTRL_RUN     = 0;
  localparam int unsigned CTRL_IRQEN   = 1;
  localparam int unsigned CTRL_ONESHOT = 2;
  localparam int unsigned STATUS_TF    = 0;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } bus_state_t;

endpackage

// File: rtl/bus_io_target_if.sv
// CPU-side bus of the I/O-page responder.
//   AB    CPU address          DO   CPU write data     WE  write enable
//   DI    registered read data dsel DI-valid mux select
//   rdy   combinational ready (low freezes the core)
// master: the CPU side, slave: bus_io_target.
interface bus_io_target_if;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;
  logic        dsel;
  logic        rdy;

  modport master (output AB, DO, WE, input DI, dsel, rdy);
  modport slave  (input AB, DO, WE, output DI, dsel, rdy);
endinterface

// File: rtl/bus_io_timer.sv
// 16-bit interval timer of the I/O page: count/reload, read shadow for
// untorn 16-bit reads, CTRL (RUN/IRQEN/ONESHOT), TF flag and irq.
// Optional prescaler enabled by defining BUS_IO_PRESCALER_EN.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   wr_en, rd_en     committed write / read to this page this cycle
//   ofs, wdata       register offset and write data
//   count, shadow    live count and latched high byte for CNT_HI reads
//   ctrl, tf         {ONESHOT,IRQEN,RUN} and timer flag
//   prescale         PRESCALE register (0 when the prescaler is absent)
//   irq              registered TF & IRQEN
module bus_io_timer
  import bus_io_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [2:0]  ofs,
  input  logic [7:0]  wdata,
  output logic [15:0] count,
  output logic [7:0]  shadow,
  output logic [2:0]  ctrl,
  output logic        tf,
  output logic [7:0]  prescale,
  output logic        irq
);

  logic [15:0] reload;
  logic        run, irqen, oneshot;
  logic        tick, expire;

  assign ctrl   = {oneshot, irqen, run};
  assign expire = run & tick & (count == '0);

`ifdef BUS_IO_PRESCALER_EN
  logic [7:0] pcnt;

  assign tick     = (pcnt == prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (wr_en && ofs == OFS_PRESCALE) prescale <= wdata;
      if (!run || (wr_en && ofs == OFS_PRESCALE) || tick) pcnt <= '0;
      else                                               pcnt <= pcnt + 8'd1;
    end
  end
`else
  assign tick     = 1'b1;
  assign prescale = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '1;
      reload  <= '1;
      shadow  <= '0;
      run     <= 1'b0;
      irqen   <= 1'b0;
      oneshot <= 1'b0;
      tf      <= 1'b0;
      irq     <= 1'b0;
    end else begin
      irq <= tf & irqen;

      // Expiry outranks a coincident write-1-to-clear.
      if (expire)
        tf <= 1'b1;
      else if (wr_en && ofs == OFS_STATUS && wdata[STATUS_TF])
        tf <= 1'b0;

      if (wr_en && ofs == OFS_CNT_LO) reload[7:0]  <= wdata;
      if (wr_en && ofs == OFS_CNT_HI) reload[15:8] <= wdata;

      if (wr_en && ofs == OFS_CNT_HI)
        count <= {wdata, reload[7:0]};
      else if (run && tick)
        count <= expire ? reload : count - 16'd1;

      if (wr_en && ofs == OFS_CTRL) begin
        run     <= wdata[CTRL_RUN];
        irqen   <= wdata[CTRL_IRQEN];
        oneshot <= wdata[CTRL_ONESHOT];
      end else if (expire && oneshot) begin
        run <= 1'b0;
      end

      if (rd_en && ofs == OFS_CNT_LO) shadow <= count[15:8];
    end
  end

endmodule

// File: rtl/bus_io_target.sv
// 65C02 I/O-page responder. Decodes AB[15:8]==IO_PAGE, inserts WAIT
// wait states through rdy, registers read data into DI with dsel, owns
// the interval timer (irq) and a software-triggered nmi pulse.
// Optional PRESCALE register at offset 7 when BUS_IO_PRESCALER_EN is defined.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          bus_io_target_if.slave (AB, DO, WE in; DI, dsel, rdy out)
//   irq          level interrupt request
//   nmi          NMI_LEN-cycle pulse
module bus_io_target
  import bus_io_pkg::*;
#(
  parameter logic [7:0]  IO_PAGE  = IO_PAGE_DEFAULT,
  parameter logic [1:0]  WAIT_RST = 2'd0,
  parameter int unsigned NMI_LEN  = 4
) (
  input  logic             clk,
  input  logic             reset,
  bus_io_target_if.slave   bus,
  output logic             irq,
  output logic             nmi
);

  localparam int unsigned NW = $clog2(NMI_LEN + 2);

  bus_state_t  state;
  logic [1:0]  wcnt;
  logic [1:0]  wait_q;
  logic [7:0]  scratch;
  logic [NW-1:0] ncnt;

  logic        hit, rdy_c, commit, wr, rd;
  logic [2:0]  ofs;
  logic [7:0]  rdata;
  logic        addr_unused;

  logic [15:0] count;
  logic [7:0]  shadow, prescale;
  logic [2:0]  ctrl;
  logic        tf;

  assign hit         = (bus.AB[15:8] == IO_PAGE);
  assign ofs         = bus.AB[2:0];
  assign addr_unused = ^bus.AB[7:3];

  always_comb begin
    rdy_c = 1'b1;
    if (!reset) begin
      if (state == ST_IDLE) rdy_c = !(hit && wait_q != '0);
      else                  rdy_c = (wcnt == '0);
    end
  end

  assign bus.rdy = rdy_c;
  assign commit  = hit & rdy_c & ~reset;
  assign wr      = commit & bus.WE;
  assign rd      = commit & ~bus.WE;

  bus_io_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr),
    .rd_en    (rd),
    .ofs      (ofs),
    .wdata    (bus.DO),
    .count    (count),
    .shadow   (shadow),
    .ctrl     (ctrl),
    .tf       (tf),
    .prescale (prescale),
    .irq      (irq)
  );

  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_CNT_LO:   rdata = count[7:0];
      OFS_CNT_HI:   rdata = shadow;
      OFS_CTRL:     rdata = {5'b0, ctrl};
      OFS_STATUS:   rdata = {7'b0, tf};
      OFS_SCRATCH:  rdata = scratch;
      OFS_WAIT:     rdata = {6'b0, wait_q};
      OFS_PRESCALE: rdata = prescale;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      wait_q   <= WAIT_RST;
      scratch  <= '0;
      bus.DI   <= '0;
      bus.dsel <= 1'b0;
      ncnt     <= '0;
      nmi      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (hit && wait_q != '0) begin
            state <= ST_WAIT;
            wcnt  <= wait_q - 2'd1;
          end
        ST_WAIT:
          if (wcnt == '0) state <= ST_IDLE;
          else            wcnt  <= wcnt - 2'd1;
        default: state <= ST_IDLE;
      endcase

      bus.dsel <= rd;
      if (rd) bus.DI <= rdata;

      if (wr && ofs == OFS_SCRATCH) scratch <= bus.DO;
      if (wr && ofs == OFS_WAIT)    wait_q  <= bus.DO[1:0];

      // ncnt runs NMI_LEN+1 .. 1: high while >=2, one forced low cycle at 1,
      // new triggers accepted only at 0.
      if (ncnt == '0) begin
        if (wr && ofs == OFS_NMI_TRIG) begin
          ncnt <= NW'(NMI_LEN + 1);
          nmi  <= 1'b1;
        end
      end else begin
        ncnt <= ncnt - NW'(1);
        nmi  <= (ncnt > NW'(2));
      end
    end
  end

endmodule
